// File: rtl/ex_pkg.sv
// Shared encodings for the execute/memory boundary: condition codes,
// branch kinds and NZCV bit positions.
package ex_pkg;

    localparam int unsigned NZCV_W = 4;
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_HS = 4'h2,
        COND_LO = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_CBZ  = 2'b10,
        BR_CBNZ = 2'b11
    } br_kind_e;

endpackage

// File: rtl/cond_eval.sv
// Branch resolution: B.cond against the pre-update NZCV register,
// CBZ/CBNZ against the instruction's own ALU zero flag.
module cond_eval
    import ex_pkg::*;
(
    input  logic [NZCV_W-1:0] flags,
    input  logic [3:0]        cond,
    input  logic [1:0]        br_kind,
    input  logic              alu_zero,
    output logic              taken
);

    logic n, z, c, v;
    logic cond_true;

    always_comb begin
        n         = flags[FLAG_N];
        z         = flags[FLAG_Z];
        c         = flags[FLAG_C];
        v         = flags[FLAG_V];
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_HS: cond_true = c;
            COND_LO: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = c & ~z;
            COND_LS: cond_true = ~c | z;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (br_kind_e'(br_kind))
            BR_COND: taken = cond_true;
            BR_CBZ:  taken = alu_zero;
            BR_CBNZ: taken = ~alu_zero;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_flags.sv
// EX/MEM pipeline register with valid/ready handshake, architectural NZCV
// register and registered branch resolution.
module ex_mem_flags
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned RW    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_carry_out,
    input  logic              set_flags,
    input  logic [WIDTH-1:0]  store_data,
    input  logic [RW-1:0]     rd,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        br_kind,
    input  logic [3:0]        cond,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [WIDTH-1:0]  out_store_data,
    output logic [RW-1:0]     out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              branch_taken,
    output logic [NZCV_W-1:0] flags
);

    logic              accept_c;
    logic              taken_c;
    logic [NZCV_W-1:0] alu_nzcv_c;

    // Single-entry buffer: free when empty or draining this cycle.
    assign in_ready = ~out_valid | out_ready;
    assign accept_c = in_valid & in_ready & ~flush;

    always_comb begin
        alu_nzcv_c         = '0;
        alu_nzcv_c[FLAG_N] = alu_negative;
        alu_nzcv_c[FLAG_Z] = alu_zero;
        alu_nzcv_c[FLAG_C] = alu_carry_out;
        alu_nzcv_c[FLAG_V] = alu_overflow;
    end

    cond_eval u_cond_eval (
        .flags    (flags),
        .cond     (cond),
        .br_kind  (br_kind),
        .alu_zero (alu_zero),
        .taken    (taken_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            branch_taken   <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            flags          <= '0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            branch_taken <= 1'b0;
        end else if (accept_c) begin
            out_valid      <= 1'b1;
            branch_taken   <= taken_c;
            out_result     <= alu_result;
            out_store_data <= store_data;
            out_rd         <= rd;
            out_reg_write  <= reg_write;
            out_mem_read   <= mem_read;
            out_mem_write  <= mem_write;
            if (set_flags) begin
                flags <= alu_nzcv_c;
            end
        end else if (out_ready) begin
            // Drained with nothing behind it; branch_taken must read 0 when empty.
            out_valid    <= 1'b0;
            branch_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_mem_flags.sv
// Directed bench for ex_mem_flags with a behavioural reference model and
// hand-computed expectations for each scenario.
module tb_ex_mem_flags;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] alu_result = '0;
    logic        alu_negative = 1'b0;
    logic        alu_zero = 1'b0;
    logic        alu_overflow = 1'b0;
    logic        alu_carry_out = 1'b0;
    logic        set_flags = 1'b0;
    logic [63:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  br_kind = '0;
    logic [3:0]  cond = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [63:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        branch_taken;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    ex_mem_flags #(.WIDTH(64), .RW(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_negative   (alu_negative),
        .alu_zero       (alu_zero),
        .alu_overflow   (alu_overflow),
        .alu_carry_out  (alu_carry_out),
        .set_flags      (set_flags),
        .store_data     (store_data),
        .rd             (rd),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .br_kind        (br_kind),
        .cond           (cond),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .branch_taken   (branch_taken),
        .flags          (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: conditions come in complementary pairs, odd code inverts.
    function automatic logic m_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v, base;
        logic [2:0] pair;
        {n, z, cy, v} = f;
        pair = c[3:1];
        case (pair)
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    logic        m_valid, m_bt, m_acc, m_keep;
    logic [3:0]  m_flags;
    logic [63:0] m_res, m_sd;
    logic [4:0]  m_rd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_bt    <= 1'b0;
            m_flags <= 4'b0000;
        end else begin
            m_acc  = in_valid && (!m_valid || out_ready) && !flush;
            m_keep = m_valid && !out_ready && !flush;
            m_valid <= m_acc || m_keep;
            if (m_acc) begin
                m_res <= alu_result;
                m_sd  <= store_data;
                m_rd  <= rd;
                case (br_kind)
                    2'b01:   m_bt <= m_cond(m_flags, cond);
                    2'b10:   m_bt <= alu_zero;
                    2'b11:   m_bt <= !alu_zero;
                    default: m_bt <= 1'b0;
                endcase
                if (set_flags)
                    m_flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
            end else if (!m_keep) begin
                m_bt <= 1'b0;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("m_out_valid", 64'(out_valid), 64'(m_valid));
        chk("m_branch_taken", 64'(branch_taken), 64'(m_bt));
        chk("m_flags", 64'(flags), 64'(m_flags));
        if (m_valid) begin
            chk("m_out_result", out_result, m_res);
            chk("m_out_store_data", out_store_data, m_sd);
            chk("m_out_rd", 64'(out_rd), 64'(m_rd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        set_flags = 1'b0;
        br_kind   = 2'b00;
        flush     = 1'b0;
    endtask

    task automatic send(input logic [63:0] res, input logic [3:0] nzcv, input logic sf,
                        input logic [1:0] bk, input logic [3:0] cd, input logic [4:0] r);
        in_valid   = 1'b1;
        alu_result = res;
        {alu_negative, alu_zero, alu_carry_out, alu_overflow} = nzcv;
        set_flags  = sf;
        br_kind    = bk;
        cond       = cd;
        rd         = r;
        store_data = ~res;
        reg_write  = 1'b1;
        mem_read   = r[0];
        mem_write  = r[1];
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_branch_taken", 64'(branch_taken), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // SUBS 5-5 then B.EQ
        send(64'd0, 4'b0110, 1'b1, 2'b00, 4'h0, 5'd1);
        step();
        chk("subs55_valid", 64'(out_valid), 64'd1);
        chk("subs55_flags", 64'(flags), 64'b0110);
        send(64'd0, 4'b0000, 1'b0, 2'b01, 4'h0, 5'd0);
        step();
        chk("beq_taken", 64'(branch_taken), 64'd1);

        // SUBS 3-5 then B.LT, B.HS
        send(64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1, 2'b00, 4'h0, 5'd2);
        step();
        chk("subs35_flags", 64'(flags), 64'b1000);
        send(64'd0, 4'b0000, 1'b0, 2'b01, 4'hB, 5'd0);
        step();
        chk("blt_taken", 64'(branch_taken), 64'd1);
        send(64'd0, 4'b0000, 1'b0, 2'b01, 4'h2, 5'd0);
        step();
        chk("bhs_taken", 64'(branch_taken), 64'd0);

        // ADDS 1+1 clears flags, plain ADD to zero leaves them, B.EQ not taken
        send(64'd2, 4'b0000, 1'b1, 2'b00, 4'h0, 5'd5);
        step();
        chk("adds_flags", 64'(flags), 64'b0000);
        send(64'd0, 4'b0100, 1'b0, 2'b00, 4'h0, 5'd6);
        step();
        chk("add_nosf_flags", 64'(flags), 64'b0000);
        send(64'd0, 4'b0000, 1'b0, 2'b01, 4'h0, 5'd0);
        step();
        chk("beq_nt_taken", 64'(branch_taken), 64'd0);

        // CBZ / CBNZ on own zero flag, and the always condition
        send(64'd0, 4'b0100, 1'b0, 2'b10, 4'h0, 5'd0);
        step();
        chk("cbz_taken", 64'(branch_taken), 64'd1);
        send(64'd0, 4'b0100, 1'b0, 2'b11, 4'h0, 5'd0);
        step();
        chk("cbnz_taken", 64'(branch_taken), 64'd0);
        send(64'd7, 4'b0000, 1'b0, 2'b01, 4'hE, 5'd0);
        step();
        chk("bal_taken", 64'(branch_taken), 64'd1);

        // Backpressure: 3-cycle stall, then back-to-back transfers
        idle();
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_taken", 64'(branch_taken), 64'd0);
        out_ready = 1'b0;
        send(64'hA1, 4'b0000, 1'b0, 2'b00, 4'h0, 5'd3);
        step();
        chk("bp_a_result", out_result, 64'hA1);
        send(64'hB2, 4'b0000, 1'b0, 2'b00, 4'h0, 5'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
            chk("bp_stall_result", out_result, 64'hA1);
            chk("bp_stall_rd", 64'(out_rd), 64'd3);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("bp_b_result", out_result, 64'hB2);
        send(64'hC3, 4'b0000, 1'b0, 2'b00, 4'h0, 5'd7);
        step();
        chk("bp_c_valid", 64'(out_valid), 64'd1);
        chk("bp_c_result", out_result, 64'hC3);

        // Flush while stalled with a flag-setting bundle incoming
        out_ready = 1'b0;
        send(64'hD4, 4'b0000, 1'b0, 2'b00, 4'h0, 5'd8);
        step();
        chk("fl_pre_valid", 64'(out_valid), 64'd1);
        send(64'hE5, 4'b0101, 1'b1, 2'b00, 4'h0, 5'd9);
        flush = 1'b1;
        step();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_flags", 64'(flags), 64'b0000);
        idle();

        // Asynchronous reset mid-cycle with flags=1111 held
        send(64'hF6, 4'b1111, 1'b1, 2'b00, 4'h0, 5'd10);
        step();
        chk("pre_rst_flags", 64'(flags), 64'b1111);
        idle();
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_flags", 64'(flags), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        send(64'h17, 4'b0010, 1'b1, 2'b00, 4'h0, 5'd11);
        step();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_flags", 64'(flags), 64'b0010);
        idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
